// File: rtl/bfs_traverse_controller_pkg.sv
// rtl/bfs_traverse_controller_pkg.sv - shared node-list field layout and BFS controller state encoding
package bfs_traverse_controller_pkg;

    localparam int NODE_W_DEF = 5;
    localparam int ADDR_W_DEF = 6;

    // Head word: {has_list, first_entry_addr}; entry word: {neighbour, has_next, next_addr}
    localparam logic LIST_PRESENT = 1'b1;
    localparam logic NEXT_PRESENT = 1'b1;

    function automatic int head_has_list_bit(input int addr_w);
        return addr_w;
    endfunction

    function automatic int entry_has_next_bit(input int addr_w);
        return addr_w;
    endfunction

    function automatic int entry_neighbour_lsb(input int addr_w);
        return addr_w + 1;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SEED,
        S_DEQUEUE,
        S_WAIT_HEAD,
        S_WAIT_ENT,
        S_DONE
    } state_t;

endpackage

// File: rtl/bfs_queue.sv
// rtl/bfs_queue.sv - synchronous FIFO of node ids with a combinationally visible head entry
module bfs_queue #(
    parameter int W  = 5,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Visited-on-enqueue bounds occupancy to DEPTH, so these can only fire on a controller bug
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/bfs_traverse_controller.sv
// rtl/bfs_traverse_controller.sv - breadth-first walk over head/entry list RAMs from a root node
module bfs_traverse_controller
    import bfs_traverse_controller_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       program_reset,
    input  logic                       start_process,
    input  logic [NODE_W-1:0]          start_node,
    output logic                       end_process,
    output logic [NODE_W-1:0]          head_rd_addr,
    input  logic [ADDR_W:0]            head_rd_data,
    output logic [ADDR_W-1:0]          entry_rd_addr,
    input  logic [NODE_W+ADDR_W:0]     entry_rd_data,
    output logic                       visit_valid,
    output logic [NODE_W-1:0]          visit_node,
    output logic [NODE_W:0]            visit_count,
    output logic                       list_error
);
    localparam int N = 1 << NODE_W;

    state_t state;
    state_t state_nx;

    logic [NODE_W-1:0] root;
    logic [N-1:0]      visited;
    logic [ADDR_W-1:0] hop_cnt;

    logic              q_push;
    logic              q_pop;
    logic              q_clear;
    logic [NODE_W-1:0] q_din;
    logic [NODE_W-1:0] q_head;
    logic              q_empty;
    logic              q_full;

    logic              head_has_list;
    logic [ADDR_W-1:0] head_first;
    logic [NODE_W-1:0] ent_nb;
    logic              ent_has_next;
    logic [ADDR_W-1:0] ent_next;
    logic              nb_new;
    logic              hop_limit;

    assign head_has_list = head_rd_data[head_has_list_bit(ADDR_W)];
    assign head_first    = head_rd_data[ADDR_W-1:0];
    assign ent_nb        = entry_rd_data[entry_neighbour_lsb(ADDR_W) +: NODE_W];
    assign ent_has_next  = entry_rd_data[entry_has_next_bit(ADDR_W)];
    assign ent_next      = entry_rd_data[ADDR_W-1:0];
    assign nb_new        = !visited[ent_nb];
    // hop_cnt counts entries already consumed; all-ones means this is the E-th entry of the list
    assign hop_limit     = &hop_cnt;

    bfs_queue #(
        .W  (NODE_W),
        .AW (NODE_W)
    ) u_queue (
        .clk   (clk),
        .rst   (program_reset),
        .clear (q_clear),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .head  (q_head),
        .empty (q_empty),
        .full  (q_full)
    );

    always_comb begin
        state_nx      = state;
        q_push        = 1'b0;
        q_pop         = 1'b0;
        q_clear       = 1'b0;
        q_din         = ent_nb;
        head_rd_addr  = '0;
        entry_rd_addr = '0;
        end_process   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_process) begin
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                q_clear  = 1'b1;
                state_nx = S_SEED;
            end
            S_SEED: begin
                q_push   = 1'b1;
                q_din    = root;
                state_nx = S_DEQUEUE;
            end
            S_DEQUEUE: begin
                if (q_empty) begin
                    state_nx = S_DONE;
                end else begin
                    q_pop        = 1'b1;
                    head_rd_addr = q_head;
                    state_nx     = S_WAIT_HEAD;
                end
            end
            S_WAIT_HEAD: begin
                if (head_has_list == LIST_PRESENT) begin
                    entry_rd_addr = head_first;
                    state_nx      = S_WAIT_ENT;
                end else begin
                    state_nx = S_DEQUEUE;
                end
            end
            S_WAIT_ENT: begin
                q_push = nb_new;
                if (ent_has_next != NEXT_PRESENT || hop_limit) begin
                    state_nx = S_DEQUEUE;
                end else begin
                    entry_rd_addr = ent_next;
                end
            end
            S_DONE: begin
                end_process = 1'b1;
                if (!start_process) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (program_reset) begin
            state       <= S_IDLE;
            root        <= '0;
            visited     <= '0;
            hop_cnt     <= '0;
            visit_valid <= 1'b0;
            visit_node  <= '0;
            visit_count <= '0;
            list_error  <= 1'b0;
        end else begin
            state       <= state_nx;
            visit_valid <= q_pop;
            if (state == S_IDLE && start_process) begin
                root <= start_node;
            end
            if (state == S_CLEAR) begin
                visited     <= '0;
                visit_count <= '0;
                list_error  <= 1'b0;
            end
            if (state == S_SEED) begin
                visited[root] <= 1'b1;
            end
            if (q_pop) begin
                visit_node  <= q_head;
                visit_count <= visit_count + (NODE_W+1)'(1);
                hop_cnt     <= '0;
            end
            if (state == S_WAIT_ENT) begin
                hop_cnt <= hop_cnt + 1'b1;
                if (nb_new) begin
                    visited[ent_nb] <= 1'b1;
                end
                if (ent_has_next == NEXT_PRESENT && hop_limit) begin
                    list_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bfs_traverse_controller.sv
// tb/tb_bfs_traverse_controller.sv - directed bench for the BFS traverse controller
module tb_bfs_traverse_controller;

    logic        clk = 1'b0;
    logic        program_reset;
    logic        start_process;
    logic [4:0]  start_node;
    logic        end_process;
    logic [4:0]  head_rd_addr;
    logic [6:0]  head_rd_data;
    logic [5:0]  entry_rd_addr;
    logic [11:0] entry_rd_data;
    logic        visit_valid;
    logic [4:0]  visit_node;
    logic [5:0]  visit_count;
    logic        list_error;

    logic [6:0]  head_ram  [32];
    logic [11:0] entry_ram [64];
    int          vis_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    bfs_traverse_controller dut (
        .clk           (clk),
        .program_reset (program_reset),
        .start_process (start_process),
        .start_node    (start_node),
        .end_process   (end_process),
        .head_rd_addr  (head_rd_addr),
        .head_rd_data  (head_rd_data),
        .entry_rd_addr (entry_rd_addr),
        .entry_rd_data (entry_rd_data),
        .visit_valid   (visit_valid),
        .visit_node    (visit_node),
        .visit_count   (visit_count),
        .list_error    (list_error)
    );

    always @(posedge clk) begin
        head_rd_data  <= head_ram[head_rd_addr];
        entry_rd_data <= entry_ram[entry_rd_addr];
    end

    always @(negedge clk) begin
        if (visit_valid) vis_q.push_back(int'(visit_node));
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_rams();
        for (int i = 0; i < 32; i++) head_ram[i] = '0;
        for (int i = 0; i < 64; i++) entry_ram[i] = '0;
    endtask

    task automatic set_head(input int node, input bit has, input int first);
        logic [5:0] f;
        f = 6'(first);
        head_ram[node] = {has, f};
    endtask

    task automatic set_entry(input int idx, input int nb, input bit has_next, input int nxt);
        logic [4:0] n;
        logic [5:0] x;
        n = 5'(nb);
        x = 6'(nxt);
        entry_ram[idx] = {n, has_next, x};
    endtask

    task automatic load_graph1();
        clear_rams();
        set_entry(0, 2, 1, 1);  set_entry(1, 1, 0, 0);
        set_entry(2, 3, 1, 3);  set_entry(3, 0, 0, 0);
        set_entry(4, 0, 0, 0);
        set_entry(5, 1, 0, 0);
        set_head(0, 1, 0); set_head(1, 1, 2); set_head(2, 1, 4); set_head(3, 1, 5);
    endtask

    task automatic start_run(input int root);
        @(posedge clk); #1;
        vis_q.delete();
        start_node    = 5'(root);
        start_process = 1'b1;
    endtask

    task automatic run_bfs(input string tag, input int root, output int cycles);
        start_run(root);
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!end_process && cycles < 3000);
        check({tag, "_done"}, end_process, 1);
    endtask

    task automatic finish_run(input string tag);
        start_process = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle"}, end_process, 0);
    endtask

    task automatic check_visits(input string tag, input int exp[$]);
        check({tag, "_nvis"}, vis_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < vis_q.size(); i++)
            check($sformatf("%s_vis%0d", tag, i), vis_q[i], exp[i]);
    endtask

    task automatic check_graph1(input string tag);
        int cyc;
        int exp[$];
        load_graph1();
        run_bfs(tag, 0, cyc);
        exp = '{0, 2, 1, 3};
        check_visits(tag, exp);
        check({tag, "_count"}, visit_count, 4);
        check({tag, "_err"}, list_error, 0);
        finish_run(tag);
    endtask

    initial begin
        int cyc;
        int exp[$];

        program_reset = 1'b1;
        start_process = 1'b0;
        start_node    = '0;
        clear_rams();
        repeat (3) @(posedge clk);
        #1;
        check("rst_end", end_process, 0);
        check("rst_valid", visit_valid, 0);
        check("rst_count", visit_count, 0);
        check("rst_err", list_error, 0);
        check("rst_haddr", head_rd_addr, 0);
        check("rst_eaddr", entry_rd_addr, 0);
        program_reset = 1'b0;

        check_graph1("t1");

        // Isolated root: CLEAR, SEED, DEQUEUE, WAIT_HEAD, DEQUEUE(empty), then DONE
        run_bfs("t2", 5, cyc);
        exp = '{5};
        check_visits("t2", exp);
        check("t2_count", visit_count, 1);
        check("t2_cycles", cyc, 6);
        finish_run("t2");

        clear_rams();
        set_entry(10, 4, 1, 11); set_entry(11, 4, 1, 12); set_entry(12, 6, 0, 0);
        set_entry(13, 4, 0, 0);
        set_head(4, 1, 10); set_head(6, 1, 13);
        run_bfs("t3", 4, cyc);
        exp = '{4, 6};
        check_visits("t3", exp);
        check("t3_count", visit_count, 2);
        check("t3_err", list_error, 0);
        finish_run("t3");

        // Self-referencing entry: 3 setup edges + WAIT_HEAD + 64 entries + DEQUEUE -> DONE at edge 70
        clear_rams();
        set_head(7, 1, 20);
        set_entry(20, 7, 1, 20);
        run_bfs("t4", 7, cyc);
        exp = '{7};
        check_visits("t4", exp);
        check("t4_count", visit_count, 1);
        check("t4_err", list_error, 1);
        check("t4_cycles", cyc, 70);
        finish_run("t4");
        check("t4_err_sticky", list_error, 1);

        check_graph1("t4clr");

        load_graph1();
        start_run(0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(visit_valid && vis_q.size() == 2) && cyc < 3000);
        check("t5_third_seen", visit_valid && vis_q.size() == 2, 1);
        program_reset = 1'b1;
        start_process = 1'b0;
        @(posedge clk); #1;
        check("t5_nvis", vis_q.size(), 3);
        check("t5_valid", visit_valid, 0);
        check("t5_end", end_process, 0);
        check("t5_count", visit_count, 0);
        check("t5_node", visit_node, 0);
        check("t5_haddr", head_rd_addr, 0);
        program_reset = 1'b0;
        check_graph1("t5re");

        clear_rams();
        for (int n = 0; n < 32; n++) set_head(n, 1, 32);
        for (int i = 0; i < 32; i++) set_entry(32 + i, i, i != 31, (33 + i) % 64);
        run_bfs("t6", 0, cyc);
        exp.delete();
        for (int i = 0; i < 32; i++) exp.push_back(i);
        check_visits("t6", exp);
        check("t6_count", visit_count, 32);
        check("t6_err", list_error, 0);
        finish_run("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
